// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the rPLL phase controller.
// The PLL_SWEEP_EN build option is handled in pll_phase_ctrl.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RST_HOLD,
    WAIT_LOCK,
    LOCKED,
    SETTLE,
    FAULT
  } state_t;

  localparam logic [3:0] FDLY_ZERO = 4'd0;

  // Timer holds at most (longest interval - 1).
  function automatic int timer_w(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_phase_ctrl_sync.sv
// Two-flop synchroniser for the asynchronous rPLL LOCK.
// Cleared by the synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_phase_ctrl.sv
// rPLL reset/lock supervisor and dynamic phase stepper.
// Define PLL_SWEEP_EN to add the automatic phase sweep.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int PS_W          = 4,
  parameter int DUTY_OFFSET   = 8,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 32,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
`ifdef PLL_SWEEP_EN
  input  logic             sweep_start,
  input  logic [15:0]      sweep_dwell,
  output logic             sweep_active,
  output logic             sweep_tick,
`endif
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic [PS_W-1:0]  psda,
  output logic [PS_W-1:0]  dutyda,
  output logic [3:0]       fdly,
  input  logic             step_valid,
  input  logic             step_dir,
  output logic             step_ready,
  output logic             locked,
  output logic             fault,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int TW = timer_w(RESET_CYCLES,
                              LOCK_TIMEOUT,
                              SETTLE_CYCLES);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] T_RST = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] T_LCK = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_SET = TW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(MAX_RETRY - 1);
  localparam logic [PS_W-1:0] DUTY = PS_W'(DUTY_OFFSET);

  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [RW-1:0] retry, retry_n;
  logic [PS_W-1:0] psda_n;
  logic lock_s, take, lost, up;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

`ifdef PLL_SWEEP_EN
  logic sweep_on, dwell_last;
  logic [PS_W-1:0] sweep_left;
  logic [15:0] dwell;

  assign dwell_last = ({1'b0, dwell} + 17'd1)
                      >= {1'b0, sweep_dwell};
  assign sweep_active = sweep_on;
  assign sweep_tick = (state == LOCKED) & sweep_on
                      & dwell_last;
  assign step_ready = (state == LOCKED) & ~sweep_on;
`else
  assign step_ready = (state == LOCKED);
`endif

  assign pll_reset = (state == RST_HOLD)
                   | (state == FAULT);
  assign locked = (state == LOCKED);
  assign fault  = (state == FAULT);
  assign fdly   = FDLY_ZERO;

  always_comb begin
    state_n = state;
    timer_n = timer - TW'(1);
    retry_n = retry;
    take    = 1'b0;
    lost    = 1'b0;
    up      = step_dir;
    unique case (state)
      RST_HOLD: begin
        if (timer == '0) begin
          state_n = WAIT_LOCK;
          timer_n = T_LCK;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_n = LOCKED;
          retry_n = '0;
        end else if (timer == '0) begin
          if (retry == R_LAST) begin
            state_n = FAULT;
          end else begin
            state_n = RST_HOLD;
            timer_n = T_RST;
            retry_n = retry + RW'(1);
          end
        end
      end
      LOCKED: begin
        if (!lock_s) lost = 1'b1;
`ifdef PLL_SWEEP_EN
        else if (sweep_on) begin
          take = dwell_last && (sweep_left != '0);
          up   = 1'b1;
        end else if (sweep_start) begin
          take = 1'b1;
          up   = 1'b1;
        end
`endif
        else if (step_valid) take = 1'b1;
      end
      SETTLE: begin
        if (!lock_s) lost = 1'b1;
        else if (timer == '0) state_n = LOCKED;
      end
      FAULT: state_n = FAULT;
      default: state_n = RST_HOLD;
    endcase
    if (take) begin
      state_n = SETTLE;
      timer_n = T_SET;
    end
    // Lock loss overrides any step taken this cycle.
    if (lost) begin
      state_n = RST_HOLD;
      timer_n = T_RST;
    end
    psda_n = up ? psda + PS_W'(1) : psda - PS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RST_HOLD;
      timer         <= T_RST;
      retry         <= '0;
      psda          <= '0;
      dutyda        <= DUTY;
      lock_loss_cnt <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      retry <= retry_n;
      if (take) begin
        psda   <= psda_n;
        dutyda <= psda_n + DUTY;
      end
      if (lost && lock_loss_cnt != '1)
        lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
    end
  end

`ifdef PLL_SWEEP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_on   <= 1'b0;
      sweep_left <= '0;
      dwell      <= '0;
    end else if (lost) begin
      sweep_on <= 1'b0;
    end else if (state == LOCKED) begin
      if (!sweep_on) begin
        if (sweep_start) begin
          sweep_on   <= 1'b1;
          sweep_left <= '1;
          dwell      <= '0;
        end
      end else if (dwell_last) begin
        dwell <= '0;
        if (sweep_left == '0) sweep_on <= 1'b0;
        else sweep_left <= sweep_left - PS_W'(1);
      end else begin
        dwell <= dwell + 16'd1;
      end
    end
  end
`endif

endmodule
